// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer
// Description : Multicycle control sequencer for an RV32I core. Steps each
//               instruction through FETCH, DECODE, EXEC, MEM and WB. Runs the
//               imem/dmem request/ready handshakes and gates the RF/PC write
//               enables from latched decoder fields. Traps on illegal
//               encodings or memory timeouts and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    input  logic               imem_ready,
    output logic               ir_we,
    input  logic               dec_reg_write,
    input  logic               dec_load,
    input  logic               dec_store,
    input  logic               dec_branch,
    input  logic [1:0]         dec_next_sel,
    input  logic               dec_illegal,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ready,
    output logic               rf_we,
    output logic               pc_we,
    output logic [1:0]         pc_sel,
    output logic [2:0]         state_o,
    output logic               trap,
    output logic [COUNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    // Wait counter only needs to reach TIMEOUT-1; TIMEOUT=0 disables it.
    localparam int              c_WAIT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int              c_WAIT_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_LAST_I[c_WAIT_W-1:0];
    localparam logic            c_TIMEOUT_EN  = (TIMEOUT > 0);

    state_t               r_state;
    logic                 r_reg_write;
    logic                 r_load;
    logic                 r_store;
    logic                 r_branch;
    logic [1:0]           r_next_sel;
    logic [c_WAIT_W-1:0]  r_wait_cnt;
    logic [COUNT_W-1:0]   r_retired;
    logic                 r_trap;

    logic                 w_wait_expired;
    logic                 w_unused_branch;

    // The wait budget is spent once the counter sits on its last value.
    assign w_wait_expired = c_TIMEOUT_EN && (r_wait_cnt == c_WAIT_LAST);

    // Branch resolution lives in the PC-select logic; the latched flag is kept
    // only so it stays visible in the register set during debug.
    assign w_unused_branch = r_branch;

    // Sequencer state, latched decoder fields, wait counter and retire count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FETCH;
            r_reg_write <= 1'b0;
            r_load      <= 1'b0;
            r_store     <= 1'b0;
            r_branch    <= 1'b0;
            r_next_sel  <= 2'b00;
            r_wait_cnt  <= '0;
            r_retired   <= '0;
            r_trap      <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    // A ready arriving on the expiry cycle still completes.
                    if (imem_ready) begin
                        r_state    <= S_DECODE;
                        r_wait_cnt <= '0;
                    end else if (w_wait_expired) begin
                        r_state    <= S_TRAP;
                        r_trap     <= 1'b1;
                        r_wait_cnt <= '0;
                    end else if (c_TIMEOUT_EN) begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    r_reg_write <= dec_reg_write;
                    r_load      <= dec_load;
                    r_store     <= dec_store;
                    r_branch    <= dec_branch;
                    r_next_sel  <= dec_next_sel;
                    if (dec_illegal || (dec_load && dec_store)) begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_wait_cnt <= '0;
                    if (r_load || r_store) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        r_state    <= S_WB;
                        r_wait_cnt <= '0;
                    end else if (w_wait_expired) begin
                        r_state    <= S_TRAP;
                        r_trap     <= 1'b1;
                        r_wait_cnt <= '0;
                    end else if (c_TIMEOUT_EN) begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                    end
                end
                S_WB: begin
                    r_retired  <= r_retired + COUNT_W'(1);
                    r_wait_cnt <= '0;
                    r_state    <= S_FETCH;
                end
                S_TRAP: begin
                    r_state <= S_TRAP;
                end
                default: begin
                    // Unused encodings 6/7 fall into the trap state.
                    r_state <= S_TRAP;
                    r_trap  <= 1'b1;
                end
            endcase
        end
    end

    // Output decode from state and latched fields; everything is held low in reset.
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 2'b00;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = r_store;
                end
                S_WB: begin
                    pc_we  = 1'b1;
                    pc_sel = r_next_sel;
                    rf_we  = r_reg_write && !r_store;
                end
                default: begin
                    imem_req = 1'b0;
                end
            endcase
        end
    end

    assign state_o = rst ? 3'd0 : r_state;
    assign trap    = !rst && r_trap;
    assign retired = rst ? '0 : r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_sequencer
// Description : Directed self-checking bench for multicycle_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;

    localparam int TIMEOUT = 16;
    localparam int COUNT_W = 4;

    // Output vector: {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel[1:0], trap}
    localparam logic [8:0] O_IDLE       = 9'b000000000;
    localparam logic [8:0] O_FETCH_WAIT = 9'b100000000;
    localparam logic [8:0] O_FETCH_HIT  = 9'b110000000;
    localparam logic [8:0] O_LOAD       = 9'b001000000;
    localparam logic [8:0] O_STORE      = 9'b001100000;
    localparam logic [8:0] O_TRAP       = 9'b000000001;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               imem_req;
    logic               imem_ready = 1'b0;
    logic               ir_we;
    logic               dec_reg_write = 1'b0;
    logic               dec_load = 1'b0;
    logic               dec_store = 1'b0;
    logic               dec_branch = 1'b0;
    logic [1:0]         dec_next_sel = 2'b00;
    logic               dec_illegal = 1'b0;
    logic               dmem_req;
    logic               dmem_we;
    logic               dmem_ready = 1'b0;
    logic               rf_we;
    logic               pc_we;
    logic [1:0]         pc_sel;
    logic [2:0]         state_o;
    logic               trap;
    logic [COUNT_W-1:0] retired;
    logic [8:0]         outs;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_sequencer #(
        .TIMEOUT (TIMEOUT),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_ready    (imem_ready),
        .ir_we         (ir_we),
        .dec_reg_write (dec_reg_write),
        .dec_load      (dec_load),
        .dec_store     (dec_store),
        .dec_branch    (dec_branch),
        .dec_next_sel  (dec_next_sel),
        .dec_illegal   (dec_illegal),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_ready    (dmem_ready),
        .rf_we         (rf_we),
        .pc_we         (pc_we),
        .pc_sel        (pc_sel),
        .state_o       (state_o),
        .trap          (trap),
        .retired       (retired)
    );

    always #5 clk = ~clk;

    assign outs = {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, trap};

    // Expected output vector for a WB cycle.
    function automatic logic [8:0] wb(input logic rf, input logic [1:0] sel);
        return {4'b0000, rf, 1'b1, sel, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_dec(input logic rw, input logic ld, input logic st,
                           input logic br, input logic [1:0] ns, input logic ill);
        dec_reg_write = rw;
        dec_load      = ld;
        dec_store     = st;
        dec_branch    = br;
        dec_next_sel  = ns;
        dec_illegal   = ill;
    endtask

    // One clock cycle: apply readies, check state and outputs mid-cycle, advance.
    task automatic vec(input string tag, input logic i_rdy, input logic d_rdy,
                       input logic [2:0] st, input logic [8:0] ex);
        imem_ready = i_rdy;
        dmem_ready = d_rdy;
        #3;
        check({tag, ".state"}, 32'(state_o), 32'(st));
        check({tag, ".outs"}, 32'(outs), 32'(ex));
        @(posedge clk);
        #1;
    endtask

    // One-cycle reset with both readies high; outputs must be forced low.
    task automatic do_reset(input string tag);
        rst        = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        #3;
        check({tag, ".rst_outs"}, 32'(outs), 32'(O_IDLE));
        check({tag, ".rst_state"}, 32'(state_o), 32'd0);
        check({tag, ".rst_retired"}, 32'(retired), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset("init");

        // R-type ALU instruction, imem_ready tied high, dmem_ready noise ignored
        set_dec(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        vec("alu.f", 1'b1, 1'b0, 3'd0, O_FETCH_HIT);
        vec("alu.d", 1'b1, 1'b1, 3'd1, O_IDLE);
        vec("alu.e", 1'b1, 1'b1, 3'd2, O_IDLE);
        vec("alu.w", 1'b1, 1'b1, 3'd4, wb(1'b1, 2'b01));
        check("alu.retired", 32'(retired), 32'd1);

        // Load with dmem_ready arriving in the fourth MEM cycle
        set_dec(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        vec("ld.f",  1'b1, 1'b0, 3'd0, O_FETCH_HIT);
        vec("ld.d",  1'b0, 1'b0, 3'd1, O_IDLE);
        vec("ld.e",  1'b0, 1'b0, 3'd2, O_IDLE);
        vec("ld.m0", 1'b0, 1'b0, 3'd3, O_LOAD);
        vec("ld.m1", 1'b0, 1'b0, 3'd3, O_LOAD);
        vec("ld.m2", 1'b0, 1'b0, 3'd3, O_LOAD);
        vec("ld.m3", 1'b0, 1'b1, 3'd3, O_LOAD);
        vec("ld.w",  1'b0, 1'b0, 3'd4, wb(1'b1, 2'b00));
        check("ld.retired", 32'(retired), 32'd2);

        // Store: reg_write set by decoder but rf_we must stay low
        set_dec(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0);
        vec("st.f",  1'b1, 1'b0, 3'd0, O_FETCH_HIT);
        vec("st.d",  1'b0, 1'b0, 3'd1, O_IDLE);
        vec("st.e",  1'b0, 1'b0, 3'd2, O_IDLE);
        vec("st.m0", 1'b0, 1'b0, 3'd3, O_STORE);
        vec("st.m1", 1'b0, 1'b1, 3'd3, O_STORE);
        vec("st.w",  1'b0, 1'b0, 3'd4, wb(1'b0, 2'b10));
        check("st.retired", 32'(retired), 32'd3);

        // Fetch timeout: TRAP exactly 16 cycles after FETCH entry, then sticky
        for (int i = 0; i < 16; i++) begin
            vec($sformatf("fto.f%0d", i), 1'b0, 1'b0, 3'd0, O_FETCH_WAIT);
        end
        for (int i = 0; i < 21; i++) begin
            vec($sformatf("fto.trap%0d", i), 1'b1, 1'b1, 3'd5, O_TRAP);
        end
        check("fto.retired", 32'(retired), 32'd3);

        // One-cycle reset clears the trap and restarts in FETCH
        do_reset("clr");
        vec("clr.f", 1'b0, 1'b0, 3'd0, O_FETCH_WAIT);

        // Illegal opcode traps out of DECODE with no write pulses
        set_dec(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1);
        vec("ill.f",    1'b1, 1'b0, 3'd0, O_FETCH_HIT);
        vec("ill.d",    1'b0, 1'b0, 3'd1, O_IDLE);
        vec("ill.trap", 1'b0, 1'b0, 3'd5, O_TRAP);
        vec("ill.hold", 1'b0, 1'b0, 3'd5, O_TRAP);
        do_reset("ill");

        // Load and store both set is also illegal
        set_dec(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
        vec("ls.f",    1'b1, 1'b0, 3'd0, O_FETCH_HIT);
        vec("ls.d",    1'b0, 1'b0, 3'd1, O_IDLE);
        vec("ls.trap", 1'b0, 1'b0, 3'd5, O_TRAP);
        do_reset("ls");

        // 17 back-to-back ALU/branch instructions: 4-bit retire count wraps
        set_dec(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
        for (int i = 0; i < 17; i++) begin
            vec($sformatf("wrap%0d.f", i), 1'b1, 1'b0, 3'd0, O_FETCH_HIT);
            vec($sformatf("wrap%0d.d", i), 1'b1, 1'b0, 3'd1, O_IDLE);
            vec($sformatf("wrap%0d.e", i), 1'b1, 1'b0, 3'd2, O_IDLE);
            vec($sformatf("wrap%0d.w", i), 1'b1, 1'b0, 3'd4, wb(1'b1, 2'b11));
            check($sformatf("wrap%0d.retired", i), 32'(retired), 32'((i + 1) % 16));
        end

        // dmem_ready on the last allowed MEM cycle wins over the timeout
        set_dec(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        vec("rw.f", 1'b1, 1'b0, 3'd0, O_FETCH_HIT);
        vec("rw.d", 1'b0, 1'b0, 3'd1, O_IDLE);
        vec("rw.e", 1'b0, 1'b0, 3'd2, O_IDLE);
        for (int i = 0; i < 15; i++) begin
            vec($sformatf("rw.m%0d", i), 1'b0, 1'b0, 3'd3, O_STORE);
        end
        vec("rw.mlast", 1'b0, 1'b1, 3'd3, O_STORE);
        vec("rw.w",     1'b0, 1'b0, 3'd4, wb(1'b0, 2'b00));
        check("rw.retired", 32'(retired), 32'd2);

        // imem_ready on the last allowed FETCH cycle wins, then a MEM timeout
        set_dec(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 15; i++) begin
            vec($sformatf("mto.f%0d", i), 1'b0, 1'b0, 3'd0, O_FETCH_WAIT);
        end
        vec("mto.flast", 1'b1, 1'b0, 3'd0, O_FETCH_HIT);
        vec("mto.d",     1'b0, 1'b0, 3'd1, O_IDLE);
        vec("mto.e",     1'b0, 1'b0, 3'd2, O_IDLE);
        for (int i = 0; i < 16; i++) begin
            vec($sformatf("mto.m%0d", i), 1'b0, 1'b0, 3'd3, O_LOAD);
        end
        vec("mto.trap", 1'b0, 1'b1, 3'd5, O_TRAP);
        check("mto.retired", 32'(retired), 32'd2);
        do_reset("mto");

        // Reset in the middle of MEM abandons the load without retiring it
        set_dec(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        vec("mm.f",  1'b1, 1'b0, 3'd0, O_FETCH_HIT);
        vec("mm.d",  1'b0, 1'b0, 3'd1, O_IDLE);
        vec("mm.e",  1'b0, 1'b0, 3'd2, O_IDLE);
        vec("mm.m0", 1'b0, 1'b0, 3'd3, O_LOAD);
        do_reset("mm");
        vec("mm.refetch", 1'b0, 1'b0, 3'd0, O_FETCH_WAIT);
        check("mm.retired", 32'(retired), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multicycle control sequencer for the RV32I core; steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Handles the instruction-memory and data-memory request/ready handshakes.
- Gates register-file and PC write enables from the decoder's control fields.
- Traps on illegal encodings or memory timeouts and counts retired instructions.

Parameters:
- TIMEOUT, 16: max wait cycles for imem_ready/dmem_ready before trapping; 0 disables timeout.
- COUNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  fetch data valid this cycle.
- ir_we  out  1  latch instruction register.
- dec_reg_write  in  1  decoder field.
- dec_load  in  1  decoder field.
- dec_store  in  1  decoder field.
- dec_branch  in  1  decoder field.
- dec_next_sel  in  2  decoder next-PC select.
- dec_illegal  in  1  opcode not recognised by decoder.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store, 0 = load; valid with dmem_req.
- dmem_ready  in  1  data access complete.
- rf_we  out  1  register-file write enable.
- pc_we  out  1  PC update enable.
- pc_sel  out  2  next-PC select applied with pc_we.
- state_o  out  3  current state code, for debug.
- trap  out  1  sticky fault flag.
- retired  out  COUNT_W  retired-instruction count.

Behaviour:
- State codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 go to TRAP on the next edge.
- Reset: while rst=1 the state register loads FETCH, and the latched fields, wait counter, retired and trap load 0.
- While rst=1, all outputs are forced to 0 combinationally. state_o reads 0.
- Reset mid-transaction abandons the instruction without retiring it. The first cycle after rst falls is FETCH with imem_req=1.
- Outputs are combinational from state and registered fields only. They have no combinational path from dec_* inputs.
- FETCH: imem_req=1.
  - When imem_ready=1: ir_we=1 for that cycle only; next state DECODE.
  - Otherwise the wait counter increments. When it reaches TIMEOUT-1 with no ready, next state TRAP.
- DECODE: one cycle. Register reg_write, load, store, branch and next_sel from dec_*.
  - If dec_illegal=1, or dec_load and dec_store are both 1, next state TRAP.
  - Otherwise next state EXEC.
- EXEC: one cycle, with no outputs asserted. Next state is MEM if latched load or store is set, else WB.
- MEM: dmem_req=1 and dmem_we=latched store, held stable until ready.
  - On dmem_ready=1 next state WB.
  - Timeout works as in FETCH. The wait counter clears on every entry to FETCH or MEM.
- WB: exactly one cycle.
  - pc_we=1 and pc_sel=latched next_sel.
  - rf_we=latched reg_write AND NOT latched store.
  - retired increments, wrapping to 0 after all-ones.
  - Next state FETCH.
- Branch: the latched branch flag does not alter sequencing; resolving the branch belongs to the PC-select logic. pc_sel still passes through.
- TRAP: all request and enable outputs are 0; trap=1. TRAP holds until rst; retired is frozen.
- A ready that arrives in the same cycle the timeout fires wins: the handshake completes and no trap is raised.
- imem_ready or dmem_ready asserted outside FETCH/MEM is ignored.
- Latency with zero-wait memory:
  - ALU/jump instruction: 4 cycles (F, D, E, W).
  - Load or store: 5 cycles.

Test Plan:
- Reset, then an R-type instruction (reg_write=1) with imem_ready tied high → states 0,1,2,4,0. ir_we pulses in cycle 0. rf_we=pc_we=1 only in cycle 3. retired=1.
- Load with dmem_ready delayed 3 cycles → dmem_req=1, dmem_we=0 for 4 cycles. Then WB with rf_we=1; 8 cycles total; retired=1.
- Store → dmem_we=1 throughout MEM, rf_we=0 in WB, pc_we=1.
- imem_ready never asserted, TIMEOUT=16 → TRAP entered 16 cycles after FETCH entry. trap stays 1 for 20 further cycles; retired is unchanged.
- dec_illegal=1, and separately dec_load=dec_store=1 → DECODE goes to TRAP with no rf_we/pc_we pulse. rst=1 for one cycle clears trap and restarts FETCH.
- COUNT_W=4, 17 back-to-back ALU instructions → retired wraps 15→0 and ends at 1. Separately, asserting rst mid-MEM → dmem_req=0 immediately and retired is not incremented.
